// File: rtl/square_duty_synth.sv
// Channel-1 square-wave sample generator; the mixer fetches samples by request/valid.
// Define SQ_LOWPASS_EN to smooth the level with a one-pole filter clocked by the step tick.
module square_duty_synth #(
  parameter logic [23:0] PHASE_INC = 24'd533100,
  parameter int          AMP_SHIFT = 14
) (
  input  logic               I_CLK33MHZ,
  input  logic               I_RESET,
  input  logic [10:0]        I_FREQUENCY,
  input  logic [1:0]         I_DUTY_CYCLE,
  input  logic [3:0]         I_VOLUME,
  input  logic               I_WAVEFORM_EN,
  input  logic               I_TRIGGER,
  input  logic               I_SAMPLE_REQ,
  output logic signed [19:0] O_SAMPLE,
  output logic               O_SAMPLE_VALID,
  output logic [2:0]         O_DUTY_POS
);

  logic [23:0]        acc_q, acc_d;
  logic               tick;
  logic [10:0]        cnt_q, cnt_d;
  logic [10:0]        reload;
  logic [2:0]         pos_q, pos_d;
  logic [7:0]         pattern;
  logic [19:0]        mag;
  logic signed [19:0] level_q, level_d;
  logic signed [19:0] sample_q, sample_d;
  logic               valid_q, valid_d;
  logic signed [19:0] out_src;

  // Carry out of the phase accumulator is the ~1.048576 MHz step tick.
  assign {tick, acc_d} = {1'b0, acc_q} + {1'b0, PHASE_INC};

  // x=0 gives 2048, which truncates to 0 and still yields a 2048-tick step.
  assign reload = 11'(12'd2048 - {1'b0, I_FREQUENCY});

  always_comb begin
    cnt_d = cnt_q;
    pos_d = pos_q;
    if (I_TRIGGER) begin
      cnt_d = reload;
      pos_d = 3'd0;
    end else if (tick) begin
      if (cnt_q == 11'd1) begin
        cnt_d = reload;
        pos_d = pos_q + 3'd1;
      end else begin
        cnt_d = cnt_q - 11'd1;
      end
    end
  end

  always_comb begin
    case (I_DUTY_CYCLE)
      2'b00:   pattern = 8'b0000_0001;
      2'b01:   pattern = 8'b1000_0001;
      2'b10:   pattern = 8'b1000_0111;
      default: pattern = 8'b0111_1110;
    endcase
  end

  assign mag = 20'(I_VOLUME) << AMP_SHIFT;

  always_comb begin
    level_d = '0;
    if (I_WAVEFORM_EN && (I_VOLUME != 4'd0)) begin
      level_d = pattern[pos_q] ? $signed(mag) : -$signed(mag);
    end
  end

`ifdef SQ_LOWPASS_EN
  logic signed [19:0] y_q, y_d, diff;
  assign diff    = level_q - y_q;
  assign y_d     = tick ? (y_q + (diff >>> 3)) : y_q;
  assign out_src = y_q;

  always_ff @(posedge I_CLK33MHZ) begin
    if (I_RESET) y_q <= '0;
    else         y_q <= y_d;
  end
`else
  assign out_src = level_q;
`endif

  assign sample_d = I_SAMPLE_REQ ? out_src : sample_q;
  assign valid_d  = I_SAMPLE_REQ;

  always_ff @(posedge I_CLK33MHZ) begin
    if (I_RESET) begin
      acc_q    <= '0;
      cnt_q    <= reload;
      pos_q    <= '0;
      level_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      level_q  <= level_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign O_SAMPLE       = sample_q;
  assign O_SAMPLE_VALID = valid_q;
  assign O_DUTY_POS     = pos_q;

endmodule

// File: tb/tb_square_duty_synth.sv
// Bench for square_duty_synth: reference model plus request scoreboard, directed scenarios.
module tb_square_duty_synth;
  localparam int PHASE_INC = 533100;

  logic               clk;
  logic               rst;
  logic [10:0]        freq;
  logic [1:0]         duty;
  logic [3:0]         vol;
  logic               en;
  logic               trig;
  logic               req;
  logic signed [19:0] O_SAMPLE;
  logic               O_SAMPLE_VALID;
  logic [2:0]         O_DUTY_POS;

  square_duty_synth dut (
    .I_CLK33MHZ    (clk),
    .I_RESET       (rst),
    .I_FREQUENCY   (freq),
    .I_DUTY_CYCLE  (duty),
    .I_VOLUME      (vol),
    .I_WAVEFORM_EN (en),
    .I_TRIGGER     (trig),
    .I_SAMPLE_REQ  (req),
    .O_SAMPLE      (O_SAMPLE),
    .O_SAMPLE_VALID(O_SAMPLE_VALID),
    .O_DUTY_POS    (O_DUTY_POS)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model, advanced at every rising edge from the same inputs as the DUT.
  logic [7:0] ptab [4];
  initial begin
    ptab[0] = 8'b0000_0001;
    ptab[1] = 8'b1000_0001;
    ptab[2] = 8'b1000_0111;
    ptab[3] = 8'b0111_1110;
  end

  int m_acc = 0, m_cnt = 0, m_pos = 0, m_level = 0, m_sample = 0, m_y = 0, m_ticks = 0;
  int sb[$];

  function automatic int model_out();
`ifdef SQ_LOWPASS_EN
    return m_y;
`else
    return m_level;
`endif
  endfunction

  always @(posedge clk) begin
    int  nacc, lvl, ncnt, npos;
    bit  tk;
    nacc = m_acc + PHASE_INC;
    tk   = (nacc >= (1 << 24));
    if (rst) begin
      m_acc    <= 0;
      m_cnt    <= 2048 - int'(freq);
      m_pos    <= 0;
      m_level  <= 0;
      m_sample <= 0;
      m_y      <= 0;
      sb.delete();
    end else begin
      if (!en || vol == 4'd0)     lvl = 0;
      else if (ptab[duty][m_pos]) lvl = int'(vol) * 16384;
      else                        lvl = -(int'(vol) * 16384);
      ncnt = m_cnt;
      npos = m_pos;
      if (trig) begin
        ncnt = 2048 - int'(freq);
        npos = 0;
      end else if (tk) begin
        if (m_cnt == 1) begin
          ncnt = 2048 - int'(freq);
          npos = (m_pos + 1) % 8;
        end else begin
          ncnt = m_cnt - 1;
        end
      end
      if (req) begin
        sb.push_back(model_out());
        m_sample <= model_out();
      end
      m_acc   <= nacc % (1 << 24);
      m_cnt   <= ncnt;
      m_pos   <= npos;
      m_level <= lvl;
      if (tk) m_ticks <= m_ticks + 1;
`ifdef SQ_LOWPASS_EN
      if (tk) m_y <= m_y + ((m_level - m_y) >>> 3);
`endif
    end
  end

  // Every request must be answered exactly one edge later with the scoreboarded value.
  always @(negedge clk) begin
    int exp_s;
    chk("duty_pos", O_DUTY_POS, m_pos);
    chk("valid", O_SAMPLE_VALID, sb.size() != 0);
    if (O_SAMPLE_VALID && sb.size() != 0) begin
      exp_s = sb.pop_front();
      chk("sample", $signed(O_SAMPLE), exp_s);
    end
    chk("hold", $signed(O_SAMPLE), m_sample);
  end

  task automatic do_req(input string tag, output int got);
    int exp_s;
    req   = 1'b1;
    exp_s = model_out();
    @(negedge clk);
    req = 1'b0;
    chk({tag, "_vld"}, O_SAMPLE_VALID, 1);
    chk(tag, $signed(O_SAMPLE), exp_s);
    got = $signed(O_SAMPLE);
    @(negedge clk);
    chk({tag, "_pulse"}, O_SAMPLE_VALID, 0);
  endtask

  task automatic wait_pos_change(input string tag, input int budget, output int ticks);
    logic [2:0] p0;
    int t0, n;
    p0 = O_DUTY_POS;
    t0 = m_ticks;
    n  = 0;
    while (O_DUTY_POS == p0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (O_DUTY_POS == p0) chk({tag, "_timeout"}, 0, 1);
    ticks = m_ticks - t0;
  endtask

  initial begin
    int g, t, t0, n, pos_cnt;
    rst = 1'b1; freq = 11'd2047; duty = 2'b10; vol = 4'd15; en = 1'b1; trig = 1'b0; req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample", $signed(O_SAMPLE), 0);
    chk("rst_valid", O_SAMPLE_VALID, 0);
    chk("rst_pos", O_DUTY_POS, 0);
    rst = 1'b0;

    // freq=2047: one step per tick, 8 ticks per wrap
    for (int i = 0; i < 8; i++) begin
      wait_pos_change("f2047", 100, t);
      chk("f2047_ticks", t, 1);
    end
    chk("f2047_wrap", O_DUTY_POS, 0);
    repeat (6) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      do_req("rand", g);
    end

    // 12.5% duty, volume 8: one positive position out of eight
    duty = 2'b00; vol = 4'd8; pos_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wait_pos_change("d00", 100, t);
      repeat (2) @(negedge clk);
      do_req("d00", g);
`ifndef SQ_LOWPASS_EN
      if (g > 0) begin
        pos_cnt++;
        chk("d00_pos_val", g, 131072);
      end else begin
        chk("d00_neg_val", g, -131072);
      end
`endif
    end
`ifndef SQ_LOWPASS_EN
    chk("d00_count", pos_cnt, 1);
`endif

    // disabled channel outputs zero, valid still pulses
    duty = 2'b10; vol = 4'd15; en = 1'b0;
    repeat (2) @(negedge clk);
    do_req("dis", g);
`ifndef SQ_LOWPASS_EN
    chk("dis_zero", g, 0);
`endif
    en = 1'b1;

    // trigger coincident with a tick at position 5: trigger wins
    n = 0;
    while (!(O_DUTY_POS == 3'd5 && (m_acc + PHASE_INC) >= (1 << 24)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("trig_found", (n < 2000), 1);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("trig_pos", O_DUTY_POS, 0);
    wait_pos_change("trig_next", 100, t);
    chk("trig_ticks", t, 1);
    chk("trig_pos1", O_DUTY_POS, 1);

    // freq 1024, change to 2000 mid-step: 1024 ticks then 48 ticks per step
    freq = 11'd1024;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    t0 = m_ticks;
    repeat (3) @(negedge clk);
    do_req("f1024_p0", g);
`ifndef SQ_LOWPASS_EN
    chk("f1024_p0_val", g, 245760);
`endif
    freq = 11'd2000;
    wait_pos_change("f1024", 40000, t);
    chk("step_1024", m_ticks - t0, 1024);
    wait_pos_change("f2000a", 3000, t);
    chk("step_48a", t, 48);
    wait_pos_change("f2000b", 3000, t);
    chk("step_48b", t, 48);
    chk("f2000_pos3", O_DUTY_POS, 3);
    repeat (2) @(negedge clk);
    do_req("f2000_p3", g);
`ifndef SQ_LOWPASS_EN
    chk("f2000_p3_val", g, -245760);
`endif

    // reset with a coincident request: request discarded, state cleared
    req = 1'b1; rst = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("mrst_valid", O_SAMPLE_VALID, 0);
    chk("mrst_pos", O_DUTY_POS, 0);
    chk("mrst_sample", $signed(O_SAMPLE), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
